bridge_spi_target: RTL

//   SPI mode-0 target that turns RP2350 SPI frames into the single-cycle register bus consumed by

---
 rtl/bridge_spi_target_pkg.sv | 24 ++
 rtl/bridge_spi_target_sync.sv | 31 +++
 rtl/bridge_spi_target.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bridge_spi_target_pkg.sv
// Shared constants, state encoding and address helper for the SPI register-bus target.
package bridge_spi_target_pkg;

   localparam int SPI_CMD_RW_BIT   = 7;
   localparam int SPI_CMD_ADDR_MSB = 6;

   // Streaming RX FIFO data register; bursts on this address do not advance.
   localparam logic [6:0] REG_RX_FIFO_DATA = 7'h20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RDATA = 2'd3
   } spi_state_t;

   function automatic logic [6:0] next_addr(input logic [6:0] i_addr, input logic [6:0] i_noinc);
      if (i_addr == i_noinc) begin
         return i_addr;
      end
      return i_addr + 7'd1;
   endfunction

endpackage

// File: rtl/bridge_spi_target_sync.sv
// N-stage synchronizer for one asynchronous SPI pin, with rise/fall detect on the last two samples.
module bridge_spi_target_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];
   assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/bridge_spi_target.sv
// SPI mode-0 target converting command/data frames into a single-cycle register bus.
// All logic runs on clk; SCK, CS_N and MOSI are oversampled.
module bridge_spi_target
   import bridge_spi_target_pkg::*;
#(
   parameter logic [6:0] NOINC_ADDR  = REG_RX_FIFO_DATA,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sck,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   output logic [6:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wen,
   input  logic [7:0] reg_rdata,
   output logic       reg_ren,
   output logic       frame_active,
   output logic       frame_abort
);

   logic w_sck, w_sck_rise, w_sck_fall;
   logic w_cs_n, w_cs_rise, w_cs_fall;
   logic w_mosi, w_mosi_rise, w_mosi_fall;
   logic [7:0] w_byte;
   logic w_unused_ok;

   spi_state_t r_state;
   logic [2:0] r_bit_cnt;
   logic [6:0] r_rx;
   logic [7:0] r_tx;
   logic [6:0] r_addr;
   logic [7:0] r_wdata;
   logic       r_wen;
   logic       r_ren;
   logic       r_abort;
   logic       r_inc;
   logic       r_peek;

   bridge_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (spi_sck),
      .o_sync  (w_sck),
      .o_rise  (w_sck_rise),
      .o_fall  (w_sck_fall)
   );

   // CS resets to "asserted" so a CS already low at reset release never looks like a fresh fall.
   bridge_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (spi_cs_n),
      .o_sync  (w_cs_n),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   bridge_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (spi_mosi),
      .o_sync  (w_mosi),
      .o_rise  (w_mosi_rise),
      .o_fall  (w_mosi_fall)
   );

   assign w_unused_ok = &{1'b0, w_sck, w_cs_n, w_mosi_rise, w_mosi_fall};
   assign w_byte      = {r_rx, w_mosi};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= 3'd0;
         r_rx      <= 7'd0;
         r_tx      <= 8'd0;
         r_addr    <= 7'd0;
         r_wdata   <= 8'd0;
         r_wen     <= 1'b0;
         r_ren     <= 1'b0;
         r_abort   <= 1'b0;
         r_inc     <= 1'b0;
         r_peek    <= 1'b0;
      end else begin
         r_wen   <= 1'b0;
         r_ren   <= 1'b0;
         r_abort <= 1'b0;
         if (w_cs_rise) begin
            // CS release has priority over a coincident SCK edge; partial bytes are dropped.
            if ((r_state != ST_IDLE) && (r_bit_cnt != 3'd0)) begin
               r_abort <= 1'b1;
            end
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_tx      <= 8'd0;
            r_inc     <= 1'b0;
            r_peek    <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_cs_fall) begin
                     r_state   <= ST_CMD;
                     r_bit_cnt <= 3'd0;
                     r_rx      <= 7'd0;
                     r_tx      <= 8'd0;
                  end
               end
               ST_CMD: begin
                  if (w_sck_rise) begin
                     r_rx      <= w_byte[6:0];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_addr <= w_byte[SPI_CMD_ADDR_MSB:0];
                        if (w_byte[SPI_CMD_RW_BIT]) begin
                           r_state <= ST_RDATA;
                           r_peek  <= 1'b1;
                        end else begin
                           r_state <= ST_WDATA;
                        end
                     end
                  end
               end
               ST_WDATA: begin
                  if (r_inc) begin
                     r_addr <= next_addr(r_addr, NOINC_ADDR);
                     r_inc  <= 1'b0;
                  end
                  if (w_sck_rise) begin
                     r_rx      <= w_byte[6:0];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_wdata <= w_byte;
                        r_wen   <= 1'b1;
                        r_inc   <= 1'b1;
                     end
                  end
               end
               ST_RDATA: begin
                  // Peek: load the head without strobing; the address moves one clk before the load.
                  if (r_inc) begin
                     r_addr <= next_addr(r_addr, NOINC_ADDR);
                     r_inc  <= 1'b0;
                     r_peek <= 1'b1;
                  end else if (r_peek) begin
                     r_tx   <= reg_rdata;
                     r_peek <= 1'b0;
                  end
                  if (w_sck_rise) begin
                     // Commit only once the host actually clocks the byte.
                     if (r_bit_cnt == 3'd0) begin
                        r_ren <= 1'b1;
                     end
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_inc <= 1'b1;
                     end
                  end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
                     r_tx <= {r_tx[6:0], 1'b0};
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign spi_miso     = r_tx[7];
   assign frame_active = (r_state != ST_IDLE);
   assign spi_miso_oe  = frame_active;
   assign reg_addr     = r_addr;
   assign reg_wdata    = r_wdata;
   assign reg_wen      = r_wen;
   assign reg_ren      = r_ren;
   assign frame_abort  = r_abort;

endmodule
